// File: rtl/de_pipe_reg_pkg.sv
// Shared definitions for the Decode->Execute pipeline register slice:
// RV32I opcode constants, the E-stage field bundle and the update selector.
package de_pipe_reg_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Everything the E stage latches from D, in one record
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] default_pc;
        logic [31:0] val1;
        logic [31:0] val2;
    } e_regs_t;

    // What the E register does on the coming edge
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,  // accept the D instruction
        UPD_HOLD   = 2'd1,  // memory stall: freeze everything
        UPD_FLUSH  = 2'd2,  // wrong-path D instruction: bubble
        UPD_BUBBLE = 2'd3   // load-use hazard: bubble and stall F/D
    } upd_t;

endpackage

// File: rtl/de_pipe_reg_if.sv
// D-side inputs and E-side outputs of the Decode->Execute pipeline register.
// master = decode/forwarding side, slave = the pipeline register itself.
interface de_pipe_reg_if;
    // decode-side bundle
    logic        d_valid;
    logic [6:0]  D_opcode;
    logic [2:0]  D_funct3;
    logic [6:0]  D_funct7;
    logic [4:0]  D_rd;
    logic [4:0]  D_rs1;
    logic [4:0]  D_rs2;
    logic [31:0] D_imm;
    logic [31:0] D_pc;
    logic [31:0] D_default_pc;
    logic [31:0] fwd_val1;
    logic [31:0] fwd_val2;
    logic        e_flush;
    logic        mem_stall;

    // execute-side bundle
    logic        e_valid;
    logic [6:0]  E_opcode;
    logic [2:0]  E_funct3;
    logic [6:0]  E_funct7;
    logic [4:0]  E_rd;
    logic [4:0]  E_rs1;
    logic [4:0]  E_rs2;
    logic [31:0] E_imm;
    logic [31:0] E_pc;
    logic [31:0] E_default_pc;
    logic [31:0] E_val1;
    logic [31:0] E_val2;
    logic        fd_stall;

    modport master (
        output d_valid, D_opcode, D_funct3, D_funct7, D_rd, D_rs1, D_rs2,
               D_imm, D_pc, D_default_pc, fwd_val1, fwd_val2, e_flush, mem_stall,
        input  e_valid, E_opcode, E_funct3, E_funct7, E_rd, E_rs1, E_rs2,
               E_imm, E_pc, E_default_pc, E_val1, E_val2, fd_stall
    );

    modport slave (
        input  d_valid, D_opcode, D_funct3, D_funct7, D_rd, D_rs1, D_rs2,
               D_imm, D_pc, D_default_pc, fwd_val1, fwd_val2, e_flush, mem_stall,
        output e_valid, E_opcode, E_funct3, E_funct7, E_rd, E_rs1, E_rs2,
               E_imm, E_pc, E_default_pc, E_val1, E_val2, fd_stall
    );
endinterface

// File: rtl/de_pipe_reg_src_use_dec.sv
// Source-operand use decode: which of rs1/rs2 an opcode actually reads.
// Shared by this register's hazard check and the F/D stall logic.
import de_pipe_reg_pkg::*;

module src_use_dec (
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // LUI, AUIPC, JAL and unknown opcodes read no source register
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_JALR:   uses_rs1 = 1'b1;
            OP_LOAD:   uses_rs1 = 1'b1;
            OP_IMM:    uses_rs1 = 1'b1;
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode->Execute pipeline register for the 5-stage RV32I core.
// Latches decoded fields and forwarded operands, inserts a one-cycle bubble
// on load-use hazards, honours redirect flushes and memory-stall freezes,
// and keeps saturating bubble counters for performance debug.
import de_pipe_reg_pkg::*;

module de_pipe_reg #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    de_pipe_reg_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    e_regs_t    e_q;
    e_regs_t    d_fields;
    logic       e_valid_q;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    upd_t       upd;

    src_use_dec u_src_use_dec (
        .opcode   (bus.D_opcode),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Gather the D-side fields into the E record layout
    always_comb begin
        d_fields            = '0;
        d_fields.opcode     = bus.D_opcode;
        d_fields.funct3     = bus.D_funct3;
        d_fields.funct7     = bus.D_funct7;
        d_fields.rd         = bus.D_rd;
        d_fields.rs1        = bus.D_rs1;
        d_fields.rs2        = bus.D_rs2;
        d_fields.imm        = bus.D_imm;
        d_fields.pc         = bus.D_pc;
        d_fields.default_pc = bus.D_default_pc;
        d_fields.val1       = bus.fwd_val1;
        d_fields.val2       = bus.fwd_val2;
    end

    // Load in E whose destination is read by the D instruction; x0 never hazards
    always_comb begin
        rs1_hit  = uses_rs1 && (e_q.rd == bus.D_rs1);
        rs2_hit  = uses_rs2 && (e_q.rd == bus.D_rs2);
        load_use = e_valid_q && bus.d_valid && (e_q.opcode == OP_LOAD) &&
                   (e_q.rd != 5'd0) && (rs1_hit || rs2_hit);
    end

    // A flush kills the dependent D instruction, so it no longer needs to wait
    assign bus.fd_stall = bus.mem_stall || (load_use && !bus.e_flush);

    // Edge action, highest priority first: freeze, flush, load-use bubble, load
    always_comb begin
        upd = UPD_LOAD;
        if (bus.mem_stall)
            upd = UPD_HOLD;
        else if (bus.e_flush)
            upd = UPD_FLUSH;
        else if (load_use)
            upd = UPD_BUBBLE;
    end

    // E register: bubbles clear only valid and opcode, the rest is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_q       <= '{pc: RESET_PC, default_pc: RESET_PC, default: '0};
        end else begin
            case (upd)
                UPD_HOLD: begin
                    e_valid_q <= e_valid_q;
                    e_q       <= e_q;
                end
                UPD_FLUSH, UPD_BUBBLE: begin
                    e_valid_q <= 1'b0;
                    e_q.opcode <= '0;
                end
                UPD_LOAD: begin
                    e_valid_q <= bus.d_valid;
                    e_q       <= d_fields;
                end
                default: begin
                    e_valid_q <= e_valid_q;
                    e_q       <= e_q;
                end
            endcase
        end
    end

    // Load-use bubble counter, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((upd == UPD_BUBBLE) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Flush bubble counter: only real (valid) D instructions count, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt <= '0;
        else if ((upd == UPD_FLUSH) && bus.d_valid && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
    end

    assign bus.e_valid      = e_valid_q;
    assign bus.E_opcode     = e_q.opcode;
    assign bus.E_funct3     = e_q.funct3;
    assign bus.E_funct7     = e_q.funct7;
    assign bus.E_rd         = e_q.rd;
    assign bus.E_rs1        = e_q.rs1;
    assign bus.E_rs2        = e_q.rs2;
    assign bus.E_imm        = e_q.imm;
    assign bus.E_pc         = e_q.pc;
    assign bus.E_default_pc = e_q.default_pc;
    assign bus.E_val1       = e_q.val1;
    assign bus.E_val2       = e_q.val2;

endmodule
